// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and byte-enable patterns.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } lsu_state_e;

  // Little-endian lane enables for an aligned access of the given size.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: lane_be = BE_BYTE << lane;
      SZ_HALF: lane_be = lane[1] ? BE_HALF_HI : BE_HALF_LO;
      SZ_WORD: lane_be = BE_WORD;
      default: lane_be = BE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the addressed lane(s) out of a memory word and extends them.
module load_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    case (size)
      SZ_BYTE: data = {{(DATA_W-8){~unsigned_ld & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = {{(DATA_W-16){~unsigned_ld & shifted[15]}}, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: registers an ALU-addressed load/store, drives the dmem handshake and returns extended
// load data. Define LSU_TIMEOUT_EN to abort requests that see no dmem_ack within TIMEOUT_CYCLES.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              lsu_error,
  output logic              busy,
  output lsu_state_e        state_dbg
);

  // Handshake: an op is accepted on a rising edge where req_valid && req_ready; dmem_req stays high
  // with every dmem_* field stable until the edge on which dmem_ack is seen.

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] steered;
  logic              illegal;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
`endif

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata       (dmem_rdata),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .unsigned_ld (uns_q),
    .data        (load_data)
  );

  always_comb begin
    illegal = (size == 2'b11) || (mem_read && mem_write) ||
              ((size == SZ_HALF) && alu_result[0]) ||
              ((size == SZ_WORD) && (alu_result[1:0] != 2'b00));
    case (size)
      SZ_BYTE: steered = {4{store_data[7:0]}};
      SZ_HALF: steered = {2{store_data[15:0]}};
      default: steered = store_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    wb_data_d = wb_data_q;
`ifdef LSU_TIMEOUT_EN
    tmo_cnt_d = 8'd0;
`endif
    case (state_q)
      IDLE: begin
        // An accept with neither read nor write is a no-op, whatever its size or address.
        if (req_valid && (mem_read || mem_write)) begin
          if (illegal) begin
            state_d = ERR;
          end else begin
            state_d = REQ;
            addr_d  = alu_result;
            we_d    = mem_write;
            size_d  = size;
            uns_d   = unsigned_ld;
            wdata_d = steered;
            be_d    = lane_be(size, alu_result[1:0]);
          end
        end
      end
      REQ: begin
        if (dmem_ack) begin
          state_d = we_q ? IDLE : RESP;
          if (!we_q) wb_data_d = load_data;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = ERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      be_q      <= BE_NONE;
      wb_data_q <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      wb_data_q <= wb_data_d;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = ~req_ready;
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign wb_valid   = (state_q == RESP);
  assign wb_data    = wb_data_q;
  assign lsu_error  = (state_q == ERR);
  assign state_dbg  = state_q;

endmodule
